// File: rtl/spi_minion_pkg.sv
// Shared definitions for the multichannel SPI minion.
// Contents:
//   state_t            frame sequencer states (IDLE, SHIFT, COMMIT)
//   *_FROM_MSB         flag positions counted from the MSB of a frame, so the
//                      values are the same for every DATA_W / N_CHAN setting
package spi_minion_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // MOSI frame flags
  localparam int PUSH_FROM_MSB     = 0;
  localparam int PULL_FROM_MSB     = 1;
  // MISO frame flags
  localparam int SPACE_FROM_MSB    = 0;
  localparam int RESP_VAL_FROM_MSB = 1;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for one asynchronous pad input, with single-cycle
// rise/fall pulses that compare synced sample n against sample n-1.
// Ports:
//   clk, reset  system clock, asynchronous active-low reset
//   d           asynchronous input
//   q           synchronised level
//   rise, fall  one-cycle edge pulses derived from q
// All flops reset to 0. This means a line that is already low when reset
// releases produces no fall pulse.
module spi_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      sync_p0 <= d;
      // ---- stage boundary: metastability settle ----
      sync_p1 <= sync_p0;
      // ---- stage boundary: previous sample for edge detect ----
      prev_p2 <= sync_p1;
    end
  end

  assign q    = sync_p1;
  assign rise = sync_p1 & ~prev_p2;
  assign fall = ~sync_p1 & prev_p2;

endmodule

// File: rtl/spi_minion_multichan.sv
// SPI minion (mode 0, MSB first) with fixed-length full-duplex frames routed
// to N_CHAN internal channels.
// Ports:
//   clk, reset           system clock, asynchronous active-low reset
//   cs, sclk, mosi       asynchronous SPI pad inputs (cs active-low)
//   miso, miso_oeb       serial out and pad output-enable bar
//   recv_val/rdy/addr/msg  hold register toward the consumer
//   send_val/rdy/msg     per-channel sources; send_rdy pulses in COMMIT
//   parity               XOR of the last committed mosi payload
//   overflow             sticky, set when a push finds the hold register full
// MOSI frame: {push, pull, addr, data}; MISO frame: {space, resp_val,
// resp_addr, resp_data}.
module spi_minion_multichan
  import spi_minion_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int N_CHAN  = 4,
  localparam int ADDR_W  = $clog2(N_CHAN),
  localparam int FRAME_W = 2 + ADDR_W + DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cs,
  input  logic                     sclk,
  input  logic                     mosi,
  output logic                     miso,
  output logic                     miso_oeb,
  output logic                     recv_val,
  input  logic                     recv_rdy,
  output logic [ADDR_W-1:0]        recv_addr,
  output logic [DATA_W-1:0]        recv_msg,
  input  logic [N_CHAN-1:0]        send_val,
  output logic [N_CHAN-1:0]        send_rdy,
  input  logic [N_CHAN*DATA_W-1:0] send_msg,
  output logic                     parity,
  output logic                     overflow
);

  localparam int CNT_W = $clog2(FRAME_W + 1);

  logic cs_q, cs_rise, cs_fall;
  logic sclk_q, sclk_rise, sclk_fall;
  logic mosi_q, mosi_rise, mosi_fall;

  spi_sync_edge u_sync_cs   (.clk(clk), .reset(reset), .d(cs),   .q(cs_q),   .rise(cs_rise),   .fall(cs_fall));
  spi_sync_edge u_sync_sclk (.clk(clk), .reset(reset), .d(sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge u_sync_mosi (.clk(clk), .reset(reset), .d(mosi), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall));

  logic unused_sync;
  assign unused_sync = sclk_q ^ mosi_rise ^ mosi_fall;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    bit_cnt;
  logic [FRAME_W-1:0]  rx_sr, tx_sr, miso_frame;
  logic                cs_armed, fall_pend, start;
  logic                resp_val;
  logic [ADDR_W-1:0]   resp_addr;
  logic [DATA_W-1:0]   resp_data;

  // Frame fields as seen in COMMIT
  logic                frm_push, frm_pull, addr_ok, chan_val;
  logic [ADDR_W-1:0]   frm_addr;
  logic [DATA_W-1:0]   frm_data, chan_msg;
  logic                commit_push, commit_pull;

  assign frm_push = rx_sr[FRAME_W-1-PUSH_FROM_MSB];
  assign frm_pull = rx_sr[FRAME_W-1-PULL_FROM_MSB];
  assign frm_addr = rx_sr[DATA_W +: ADDR_W];
  assign frm_data = rx_sr[DATA_W-1:0];
  assign addr_ok  = (int'(frm_addr) < N_CHAN);
  assign chan_val = addr_ok && send_val[frm_addr];
  assign chan_msg = send_msg[frm_addr*DATA_W +: DATA_W];

  // A cs fall that lands while COMMIT is still running is remembered for IDLE.
  assign start = cs_fall | fall_pend;

  // cs_armed stays low until cs has been seen high after reset, so the pad
  // is not driven for a frame that was already in progress at reset release.
  assign miso_oeb = ~(cs_armed & ~cs_q);

  always_comb begin
    miso_frame = {2'b00, resp_addr, resp_data};
    miso_frame[FRAME_W-1-SPACE_FROM_MSB]    = ~recv_val;
    miso_frame[FRAME_W-1-RESP_VAL_FROM_MSB] = resp_val;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cs_rise) state_nxt = (bit_cnt == CNT_W'(FRAME_W)) ? COMMIT : IDLE;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / commit decode
  always_comb begin
    send_rdy    = '0;
    commit_push = 1'b0;
    commit_pull = 1'b0;
    if (state == COMMIT) begin
      commit_push = frm_push && addr_ok;
      commit_pull = frm_pull;
      if (frm_pull && chan_val) send_rdy[frm_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_armed  <= 1'b0;
      fall_pend <= 1'b0;
    end else begin
      cs_armed  <= cs_armed | cs_rise;
      fall_pend <= (state == COMMIT) && cs_fall;
    end
  end

  // Shift registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt <= '0;
      rx_sr   <= '0;
      tx_sr   <= '0;
      miso    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          tx_sr   <= miso_frame << 1;
          miso    <= miso_frame[FRAME_W-1];
          bit_cnt <= '0;
        end
        SHIFT: begin
          if (sclk_rise) begin
            rx_sr <= {rx_sr[FRAME_W-2:0], mosi_q};
            if (bit_cnt != CNT_W'(FRAME_W)) bit_cnt <= bit_cnt + 1'b1;
          end
          if (sclk_fall) begin
            miso  <= tx_sr[FRAME_W-1];
            tx_sr <= tx_sr << 1;
          end
        end
        default: ;
      endcase
    end
  end

  // Hold register, parity and overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      recv_val  <= 1'b0;
      recv_addr <= '0;
      recv_msg  <= '0;
      parity    <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (recv_val && recv_rdy) recv_val <= 1'b0;
      if (commit_push) begin
        if (!recv_val) begin
          recv_val  <= 1'b1;
          recv_addr <= frm_addr;
          recv_msg  <= frm_data;
        end else begin
          overflow  <= 1'b1;
        end
      end
      if (state == COMMIT) parity <= ^frm_data;
    end
  end

  // Response register, read out by the next frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_val  <= 1'b0;
      resp_addr <= '0;
      resp_data <= '0;
    end else if (commit_pull) begin
      resp_val  <= chan_val;
      resp_addr <= frm_addr;
      resp_data <= chan_val ? chan_msg : '0;
    end
  end

endmodule

// File: tb/tb_spi_minion_multichan.sv
module tb_spi_minion_multichan;

  localparam int DATA_W  = 8;
  localparam int N_CHAN  = 4;
  localparam int ADDR_W  = 2;
  localparam int FRAME_W = 12;
  localparam int HALF    = 6;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     cs = 1'b1, sclk = 1'b0, mosi = 1'b0;
  logic                     miso, miso_oeb;
  logic                     recv_val, recv_rdy = 1'b1;
  logic [ADDR_W-1:0]        recv_addr;
  logic [DATA_W-1:0]        recv_msg;
  logic [N_CHAN-1:0]        send_val = '0;
  logic [N_CHAN-1:0]        send_rdy;
  logic [N_CHAN*DATA_W-1:0] send_msg = '0;
  logic                     parity, overflow;

  spi_minion_multichan #(.DATA_W(DATA_W), .N_CHAN(N_CHAN)) dut (
    .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi),
    .miso(miso), .miso_oeb(miso_oeb),
    .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_addr(recv_addr), .recv_msg(recv_msg),
    .send_val(send_val), .send_rdy(send_rdy), .send_msg(send_msg),
    .parity(parity), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Handshake / pulse monitors, sampled on the falling edge
  int                rv_cycles = 0;
  int                hs_cnt = 0;
  logic [ADDR_W-1:0] hs_addr = '0;
  logic [DATA_W-1:0] hs_msg = '0;
  int                rdy_cnt [N_CHAN] = '{default: 0};

  always @(negedge clk) begin
    if (recv_val) rv_cycles <= rv_cycles + 1;
    if (recv_val && recv_rdy) begin
      hs_cnt  <= hs_cnt + 1;
      hs_addr <= recv_addr;
      hs_msg  <= recv_msg;
    end
    for (int k = 0; k < N_CHAN; k++)
      if (send_rdy[k]) rdy_cnt[k] <= rdy_cnt[k] + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [FRAME_W-1:0] mk(input logic push, input logic pull,
                                            input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    return {push, pull, a, d};
  endfunction

  task automatic spi_xfer(input logic [FRAME_W-1:0] tx, input int nbits, output logic [FRAME_W-1:0] rx);
    rx = '0;
    cs = 1'b0;
    mosi = tx[FRAME_W-1];
    cyc(8);
    chk("oeb_in_frame", miso_oeb, 0);
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[FRAME_W-1-i];
      rx[FRAME_W-1-i] = miso;
      sclk = 1'b1;
      cyc(HALF);
      sclk = 1'b0;
      cyc(HALF);
    end
    cs = 1'b1;
    mosi = 1'b0;
    cyc(10);
  endtask

  logic [FRAME_W-1:0] rx;
  int hs0, rv0;

  initial begin
    // Reset values
    cyc(3);
    chk("rst_miso", miso, 0);
    chk("rst_oeb", miso_oeb, 1);
    chk("rst_recv_val", recv_val, 0);
    chk("rst_recv_addr", recv_addr, 0);
    chk("rst_recv_msg", recv_msg, 0);
    chk("rst_send_rdy", send_rdy, 0);
    chk("rst_parity", parity, 0);
    chk("rst_overflow", overflow, 0);
    reset = 1'b1;
    cyc(10);

    // Push A5 to channel 2
    rv0 = rv_cycles;
    spi_xfer(mk(1, 0, 2'd2, 8'hA5), FRAME_W, rx);
    chk("push_miso", rx, 12'h800);
    chk("push_hs", hs_cnt, 1);
    chk("push_val_cycles", rv_cycles - rv0, 1);
    chk("push_addr", hs_addr, 2);
    chk("push_msg", hs_msg, 8'hA5);
    chk("push_parity", parity, 0);

    // Pull channel 1, then read the response with a no-op frame
    send_val = 4'b0010;
    send_msg = {8'h00, 8'h00, 8'h3C, 8'h00};
    spi_xfer(mk(0, 1, 2'd1, 8'h00), FRAME_W, rx);
    send_val = '0;
    chk("pull_miso", rx, 12'h800);
    chk("pull_rdy1", rdy_cnt[1], 1);
    chk("pull_rdy0", rdy_cnt[0], 0);
    chk("pull_rdy2", rdy_cnt[2], 0);
    chk("pull_rdy3", rdy_cnt[3], 0);
    spi_xfer(mk(0, 0, 2'd0, 8'h00), FRAME_W, rx);
    chk("resp_miso", rx, 12'hD3C);
    chk("noop_hs", hs_cnt, 1);

    // Two pushes with the consumer stalled
    recv_rdy = 1'b0;
    spi_xfer(mk(1, 0, 2'd3, 8'h07), FRAME_W, rx);
    chk("ovf1_miso", rx, 12'hD3C);
    chk("ovf1_val", recv_val, 1);
    chk("ovf1_addr", recv_addr, 3);
    chk("ovf1_msg", recv_msg, 8'h07);
    chk("ovf1_parity", parity, 1);
    chk("ovf1_overflow", overflow, 0);
    spi_xfer(mk(1, 0, 2'd0, 8'h03), FRAME_W, rx);
    chk("ovf2_miso", rx, 12'h53C);
    chk("ovf2_overflow", overflow, 1);
    chk("ovf2_addr", recv_addr, 3);
    chk("ovf2_msg", recv_msg, 8'h07);
    chk("ovf2_parity", parity, 0);
    recv_rdy = 1'b1;
    cyc(3);
    chk("ovf_drain_val", recv_val, 0);
    chk("ovf_drain_hs", hs_cnt, 2);
    chk("ovf_drain_msg", hs_msg, 8'h07);

    // Short frame: 9 bits only
    send_val = 4'b0010;
    rv0 = rv_cycles;
    spi_xfer(mk(1, 1, 2'd1, 8'hFF), 9, rx);
    send_val = '0;
    chk("short_val", rv_cycles - rv0, 0);
    chk("short_rdy1", rdy_cnt[1], 1);
    chk("short_parity", parity, 0);
    chk("short_overflow", overflow, 1);

    // Reset after 5 bits of a frame
    cs = 1'b0;
    cyc(8);
    for (int i = 0; i < 5; i++) begin
      mosi = i[0];
      sclk = 1'b1;
      cyc(HALF);
      sclk = 1'b0;
      cyc(HALF);
    end
    reset = 1'b0;
    cyc(2);
    chk("midrst_miso", miso, 0);
    chk("midrst_oeb", miso_oeb, 1);
    chk("midrst_recv_val", recv_val, 0);
    chk("midrst_recv_addr", recv_addr, 0);
    chk("midrst_recv_msg", recv_msg, 0);
    chk("midrst_send_rdy", send_rdy, 0);
    chk("midrst_parity", parity, 0);
    chk("midrst_overflow", overflow, 0);
    cs = 1'b1;
    mosi = 1'b0;
    cyc(3);
    reset = 1'b1;
    cyc(10);
    hs0 = hs_cnt;
    spi_xfer(mk(1, 0, 2'd1, 8'h80), FRAME_W, rx);
    chk("postrst_miso", rx, 12'h800);
    chk("postrst_hs", hs_cnt - hs0, 1);
    chk("postrst_addr", hs_addr, 1);
    chk("postrst_msg", hs_msg, 8'h80);
    chk("postrst_parity", parity, 1);

    // Pull an empty channel, then push+pull in one frame
    spi_xfer(mk(0, 1, 2'd2, 8'h00), FRAME_W, rx);
    chk("empty_rdy2", rdy_cnt[2], 0);
    send_val = 4'b1000;
    send_msg = {8'h77, 8'h00, 8'h00, 8'h00};
    hs0 = hs_cnt;
    spi_xfer(mk(1, 1, 2'd3, 8'h5A), FRAME_W, rx);
    send_val = '0;
    chk("empty_space", rx[FRAME_W-1], 1);
    chk("empty_resp_val", rx[FRAME_W-2], 0);
    chk("combo_hs", hs_cnt - hs0, 1);
    chk("combo_addr", hs_addr, 3);
    chk("combo_msg", hs_msg, 8'h5A);
    chk("combo_rdy3", rdy_cnt[3], 1);
    chk("combo_parity", parity, 0);
    spi_xfer(mk(0, 0, 2'd0, 8'h00), FRAME_W, rx);
    chk("combo_resp_miso", rx, 12'hF77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_minion_multichan.md
# spi_minion_multichan

Parametrised SPI minion that replaces the single-stream chip-level SPI endpoint behind the caravel GPIO pads. It synchronises `cs`/`sclk`/`mosi` into the `clk` domain, exchanges fixed-length full-duplex frames, and routes the payload to one of `N_CHAN` internal channels. Each channel has valid/ready handshakes in both directions. Frame parity and a sticky overflow flag are exported for pad-level debug.

## Interface
- `DATA_W`, 8: payload bits per frame.
- `N_CHAN`, 4: channel count, ≥2. `ADDR_W = $clog2(N_CHAN)` is derived, not overridable.
- `FRAME_W` is derived: `2 + ADDR_W + DATA_W`.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `cs`  in  1  SPI chip select, active-low, asynchronous to `clk`.
- `sclk`  in  1  SPI clock, asynchronous; mode 0.
- `mosi`  in  1  serial data in, MSB first.
- `miso`  out  1  serial data out, MSB first.
- `miso_oeb`  out  1  pad output-enable bar; 0 only while synchronised `cs` is low.
- `recv_val`  out  1  delivered payload is valid.
- `recv_rdy`  in  1  consumer accepts the payload.
- `recv_addr`  out  ADDR_W  destination channel of the delivered payload.
- `recv_msg`  out  DATA_W  delivered payload.
- `send_val`  in  N_CHAN  per-channel data available.
- `send_rdy`  out  N_CHAN  per-channel one-cycle pop pulse.
- `send_msg`  in  N_CHAN*DATA_W  per-channel data; channel k occupies `[k*DATA_W +: DATA_W]`.
- `parity`  out  1  XOR of the last committed mosi payload.
- `overflow`  out  1  sticky; set when a push is dropped.

## Operation
- Pad inputs pass through 2-flop synchronisers. Edges are detected from synced sample n vs n-1.
- MOSI frame, MSB first: `{push, pull, addr[ADDR_W-1:0], data[DATA_W-1:0]}`.
- MISO frame, MSB first: `{space, resp_val, resp_addr, resp_data}`.
  - `space` = 1 when the hold register is empty.
  - The `resp_*` fields come from the response register, which was filled by the previous frame's pull.
- State machine `IDLE -> SHIFT -> COMMIT -> IDLE`.
- IDLE:
  - On synced `cs` fall, load the tx shift register with the MISO frame and drive `miso` = its MSB.
  - Clear `bit_cnt`. Go to SHIFT.
- SHIFT:
  - On `sclk` rise, shift in `mosi` and increment `bit_cnt`, saturating at `FRAME_W`.
  - On `sclk` fall, present the next tx bit on `miso`.
  - On `cs` rise: if `bit_cnt == FRAME_W`, go to COMMIT. Otherwise discard the frame and go to IDLE. A discarded frame has no side effects.
- COMMIT (one cycle):
  - `push=1` and `addr<N_CHAN`:
    - Hold register empty: load it and assert `recv_val`.
    - Hold register occupied: drop the payload and set `overflow`.
  - `pull=1` and `addr<N_CHAN`:
    - `send_val[addr]=1`: pulse `send_rdy[addr]` and capture `{1, addr, send_msg[addr]}` into the response register.
    - Otherwise capture `resp_val=0`.
  - `pull=0`: the response register keeps its contents.
  - `addr>=N_CHAN`: push is ignored with no overflow, and a pull captures `resp_val=0`.
  - `parity <= ^data` on every committed frame.
- Hold register: `recv_val` stays high until the cycle `recv_val && recv_rdy`, then clears. The hold register can be loaded again in a later COMMIT, not the same cycle.
- `overflow` clears only on reset.

## Timing
- Reset values:
  - `miso`=0, `miso_oeb`=1.
  - `recv_val`=0, `recv_addr`=0, `recv_msg`=0.
  - `send_rdy`=0, `parity`=0, `overflow`=0.
  - Response register = 0; state IDLE.
- Input-to-effect latency is 3 `clk` cycles (2 sync + 1 edge detect).
- `sclk` high and low phases must each be ≥4 `clk` periods. `cs` setup to the first `sclk` rise and hold after the last `sclk` fall must also be ≥4 `clk` periods.
- `recv_val` rises 1 cycle after COMMIT. `send_rdy` is high exactly in the COMMIT cycle.
- An in-order `cs` rise then fall within the sync window is legal: COMMIT completes before the next IDLE load.
- Asynchronous reset mid-frame aborts the frame with no handshake. A frame in progress when reset deasserts is ignored until the next `cs` fall seen from IDLE.
- `sclk` edges while in IDLE or COMMIT are ignored.

## Structure
- Package `spi_minion_pkg`:
  - the state enum (`IDLE`, `SHIFT`, `COMMIT`);
  - bit-position localparams for the `push`/`pull` and `space`/`resp_val` flags.
- Sub-module `spi_sync_edge`: 2-flop synchroniser with rise/fall pulse outputs, instantiated three times.
- Shift registers, hold register and response register live in the top module.

## Test plan
- Reset mid-frame (`DATA_W=8`, `N_CHAN=4`): assert `reset` after 5 bits → all outputs at reset values. A following clean push frame delivers normally.
- Push `{1,0,2'd2,8'hA5}` with `recv_rdy=1` → `recv_val` high for 1 cycle with `recv_addr`=2, `recv_msg`=A5; `parity`=0.
- Pull ch1 with `send_val[1]=1`, `send_msg` ch1=8'h3C → single `send_rdy[1]` pulse. The next frame's MISO = `{1,1,2'd1,8'h3C}`.
- Two pushes with `recv_rdy=0` → second dropped, `overflow`=1. The second frame's MISO `space` bit = 0.
- Short frame (`cs` rises after 9 bits) → no `recv_val`, no `send_rdy`, `parity` unchanged.
- Pull an empty channel, then push+pull in one frame → `resp_val`=0 in the next MISO frame. The combined frame performs both actions in the same COMMIT.
